// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default opcode for the fetch front end
package fetch_pkg;
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;
  localparam logic [7:0] NOP_DEFAULT = 8'h00;
endpackage

// File: rtl/fetch_stage_reg.sv
// fetch_stage_reg: one pipeline stage, data plus valid, with hold over flush over load
module fetch_stage_reg #(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_OPCODE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  d_valid,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q       <= NOP_OPCODE;
      q_valid <= 1'b0;
    end else if (!hold) begin
      q       <= flush ? NOP_OPCODE : d;
      q_valid <= !flush && d_valid;
    end
endmodule

// File: rtl/fetch_pipeline.sv
// fetch_pipeline: PC plus N-deep instruction pipeline with jump flush, stall and drain-then-halt
module fetch_pipeline import fetch_pkg::*; #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_OPCODE = DATA_WIDTH'(NOP_DEFAULT)
) (
  input  logic                        CLK,
  input  logic                        RST,
  output logic [ADDR_WIDTH-1:0]       MEM_ADDR,
  input  logic [DATA_WIDTH-1:0]       MEM_DATA,
  input  logic                        STALL,
  input  logic                        LOAD,
  input  logic [ADDR_WIDTH-1:0]       LOAD_ADDR,
  input  logic                        HALT_REQ,
  output logic [ADDR_WIDTH-1:0]       PC,
  output logic [DEPTH*DATA_WIDTH-1:0] STAGE_DATA,
  output logic [DEPTH-1:0]            STAGE_VALID,
  output logic                        HALTED
);
  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic                    halted;
  logic                    hold;
  logic                    bubble;
  logic                    drained;
  logic [DEPTH-1:0]        shifted_valid;
  logic [DATA_WIDTH-1:0]   head_data;
  assign MEM_ADDR = pc;
  assign PC = pc;
  assign HALTED = halted;
  // HALTED freezes the pipe unless a jump restarts it
  assign hold = STALL || (state == ST_HALTED && !LOAD);
  assign bubble = state != ST_RUN || HALT_REQ;
  assign head_data = bubble ? NOP_OPCODE : MEM_DATA;
  assign shifted_valid = STAGE_VALID << 1;
  assign drained = shifted_valid == '0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      fetch_stage_reg #(.DATA_WIDTH(DATA_WIDTH), .NOP_OPCODE(NOP_OPCODE)) u_reg (
        .clk(CLK), .rst(RST), .hold(hold), .flush(LOAD),
        .d(head_data), .d_valid(!bubble),
        .q(STAGE_DATA[0 +: DATA_WIDTH]), .q_valid(STAGE_VALID[0])
      );
    end else begin : g_body
      fetch_stage_reg #(.DATA_WIDTH(DATA_WIDTH), .NOP_OPCODE(NOP_OPCODE)) u_reg (
        .clk(CLK), .rst(RST), .hold(hold), .flush(LOAD),
        .d(STAGE_DATA[(i-1)*DATA_WIDTH +: DATA_WIDTH]), .d_valid(STAGE_VALID[i-1]),
        .q(STAGE_DATA[i*DATA_WIDTH +: DATA_WIDTH]), .q_valid(STAGE_VALID[i])
      );
    end
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      pc     <= RESET_VECTOR;
      state  <= ST_RUN;
      halted <= 1'b0;
    end else if (!STALL) begin
      if (LOAD) begin
        pc     <= LOAD_ADDR;
        state  <= ST_RUN;
        halted <= 1'b0;
      end else begin
        case (state)
          ST_RUN:
            if (HALT_REQ) state <= ST_DRAIN;
            else pc <= pc + ADDR_WIDTH'(1);
          ST_DRAIN:
            if (drained) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end
          ST_HALTED: halted <= 1'b1;
          default: begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        endcase
      end
    end
endmodule
